// File: rtl/playback_sequencer_pkg.sv
// Shared definitions for the playback sequencer: state encoding, memory word
// field conventions and small helpers used by the top and the unit timer.
package playback_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REWIND = 3'd1,
    ST_FETCH  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_PLAY   = 3'd4,
    ST_GAP    = 3'd5,
    ST_PAUSED = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  // A memory word is {note, len}; len == END_MARKER_LEN terminates the song.
  localparam int unsigned END_MARKER_LEN = 32'd0;
  localparam int unsigned REST_NOTE      = 32'd0;

  function automatic int unsigned presc_width(input int unsigned cycles);
    return (cycles > 32'd1) ? int'($clog2(cycles)) : 32'd1;
  endfunction

  function automatic logic is_busy_state(input state_t s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/playback_sequencer_unit_timer.sv
// Prescaler plus down-counter of time units, shared by the PLAY and GAP phases.
// o_last flags the final cycle of the loaded interval (valid while enabled).
module playback_sequencer_unit_timer
  import playback_sequencer_pkg::*;
#(
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned UNIT_CYCLES = 6_250_000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_last
);

  localparam int unsigned PRESC_W = presc_width(UNIT_CYCLES);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(UNIT_CYCLES - 32'd1);

  logic [PRESC_W-1:0] r_presc;
  logic [LEN_W-1:0]   r_units;
  logic               w_wrap;

  assign w_wrap = (r_presc == PRESC_MAX);
  assign o_last = w_wrap && (r_units <= LEN_W'(1));

  // Load clears the prescaler; each prescaler wrap consumes one time unit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_units <= '0;
    end else if (i_load) begin
      r_presc <= '0;
      r_units <= i_load_val;
    end else if (i_en) begin
      if (w_wrap) begin
        r_presc <= '0;
        if (r_units != '0) begin
          r_units <= r_units - LEN_W'(1);
        end else begin
          r_units <= r_units;
        end
      end else begin
        r_presc <= r_presc + PRESC_W'(1);
      end
    end else begin
      r_presc <= r_presc;
      r_units <= r_units;
    end
  end

endmodule

// File: rtl/playback_sequencer.sv
// Read-side controller of the music memory: rewinds, fetches one note word at a
// time, holds it for its length in time units and inserts a silent gap after it.
module playback_sequencer
  import playback_sequencer_pkg::*;
#(
  parameter int unsigned NOTE_W      = 8,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned DATA_W      = NOTE_W + LEN_W,
  parameter int unsigned DEPTH_W     = 8,
  parameter int unsigned UNIT_CYCLES = 6_250_000,
  parameter int unsigned GAP_UNITS   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_pause,
  input  logic [DATA_W-1:0]  i_mem_data,
  input  logic               i_mem_ready,
  input  logic [DEPTH_W-1:0] i_mem_duration,
  output logic               o_mem_read_en,
  output logic               o_mem_read_rst,
  output logic [NOTE_W-1:0]  o_note_out,
  output logic               o_note_valid,
  output logic [DEPTH_W-1:0] o_position,
  output logic               o_busy,
  output logic               o_finished
);

  localparam logic [LEN_W-1:0]  GAP_LOAD = LEN_W'(GAP_UNITS);
  localparam logic [LEN_W-1:0]  END_LEN  = LEN_W'(END_MARKER_LEN);
  localparam logic [NOTE_W-1:0] REST     = NOTE_W'(REST_NOTE);

  state_t             r_state;
  state_t             w_next_state;
  state_t             r_saved;
  state_t             w_next_saved;
  logic [NOTE_W-1:0]  r_note;
  logic [NOTE_W-1:0]  w_next_note;
  logic [DEPTH_W-1:0] r_position;
  logic [DEPTH_W-1:0] w_next_position;
  logic [DEPTH_W-1:0] w_pos_inc;
  logic [NOTE_W-1:0]  w_mem_note;
  logic [LEN_W-1:0]   w_mem_len;
  logic               w_stop_abort;
  logic               w_timer_load;
  logic [LEN_W-1:0]   w_timer_load_val;
  logic               w_timer_en;
  logic               w_timer_last;

  logic               r_mem_read_en;
  logic               r_mem_read_rst;
  logic [NOTE_W-1:0]  r_note_out;
  logic               r_note_valid;
  logic               r_busy;
  logic               r_finished;

  assign w_mem_note = i_mem_data[DATA_W-1:LEN_W];
  assign w_mem_len  = i_mem_data[LEN_W-1:0];
  // position saturates at the stored entry count
  assign w_pos_inc  = (r_position < i_mem_duration) ? (r_position + DEPTH_W'(1)) : r_position;

  playback_sequencer_unit_timer #(
    .LEN_W       (LEN_W),
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_unit_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_load_val),
    .i_en       (w_timer_en),
    .o_last     (w_timer_last)
  );

  // Next-state, timer control and datapath updates; stop outranks everything.
  always_comb begin
    w_next_state     = r_state;
    w_next_saved     = r_saved;
    w_next_note      = r_note;
    w_next_position  = r_position;
    w_stop_abort     = 1'b0;
    w_timer_load     = 1'b0;
    w_timer_load_val = '0;
    w_timer_en       = 1'b0;
    if (i_stop && (r_state != ST_IDLE)) begin
      w_next_state = ST_IDLE;
      w_stop_abort = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start && (r_state == ST_IDLE) && (i_mem_duration == '0)) begin
            w_next_state = ST_DONE;
          end else if (i_start) begin
            w_next_state    = ST_REWIND;
            w_next_position = '0;
          end else begin
            w_next_state = r_state;
          end
        end
        ST_REWIND: begin
          w_next_state = ST_FETCH;
        end
        ST_FETCH: begin
          if (r_position >= i_mem_duration) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_mem_ready) begin
            w_next_note = w_mem_note;
            if (w_mem_len == END_LEN) begin
              w_next_state = ST_DONE;
            end else begin
              w_next_state     = ST_PLAY;
              w_timer_load     = 1'b1;
              w_timer_load_val = w_mem_len;
            end
          end else begin
            w_next_state = ST_WAIT;
          end
        end
        ST_PLAY, ST_GAP: begin
          if (i_pause) begin
            // The pausing cycle still counts unless it would end the interval.
            w_next_state = ST_PAUSED;
            w_next_saved = r_state;
            w_timer_en   = !w_timer_last;
          end else begin
            w_timer_en = 1'b1;
            if (w_timer_last && (r_state == ST_PLAY) && (GAP_UNITS != 32'd0)) begin
              w_next_state     = ST_GAP;
              w_timer_load     = 1'b1;
              w_timer_load_val = GAP_LOAD;
            end else if (w_timer_last) begin
              w_next_state    = ST_FETCH;
              w_next_position = w_pos_inc;
            end else begin
              w_next_state = r_state;
            end
          end
        end
        ST_PAUSED: begin
          if (i_pause) begin
            w_next_state = ST_PAUSED;
          end else begin
            w_next_state = r_saved;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // State register and registered outputs derived from the upcoming state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_saved        <= ST_PLAY;
      r_note         <= '0;
      r_position     <= '0;
      r_mem_read_en  <= 1'b0;
      r_mem_read_rst <= 1'b0;
      r_note_out     <= '0;
      r_note_valid   <= 1'b0;
      r_busy         <= 1'b0;
      r_finished     <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_saved        <= w_next_saved;
      r_note         <= w_next_note;
      r_position     <= w_next_position;
      r_mem_read_en  <= (w_next_state == ST_FETCH) && (w_next_position < i_mem_duration);
      r_mem_read_rst <= (w_next_state == ST_REWIND) || w_stop_abort;
      r_note_out     <= (w_next_state == ST_PLAY) ? w_next_note : '0;
      r_note_valid   <= (w_next_state == ST_PLAY) && (w_next_note != REST);
      r_busy         <= is_busy_state(w_next_state);
      r_finished     <= (w_next_state == ST_DONE) && (r_state != ST_DONE);
    end
  end

  assign o_mem_read_en  = r_mem_read_en;
  assign o_mem_read_rst = r_mem_read_rst;
  assign o_note_out     = r_note_out;
  assign o_note_valid   = r_note_valid;
  assign o_position     = r_position;
  assign o_busy         = r_busy;
  assign o_finished     = r_finished;

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed self-checking bench for playback_sequencer with a small behavioural
// memory responder (UNIT_CYCLES = 4, GAP_UNITS = 1).
module tb_playback_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        pause;
  logic [11:0] mem_data;
  logic        mem_ready;
  logic [7:0]  mem_duration;
  logic        mem_read_en;
  logic        mem_read_rst;
  logic [7:0]  note_out;
  logic        note_valid;
  logic [7:0]  position;
  logic        busy;
  logic        finished;

  logic [11:0] mem_arr [0:7];
  logic [7:0]  mem_ptr;
  logic        mem_hold;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  playback_sequencer #(
    .NOTE_W(8), .LEN_W(4), .DATA_W(12), .DEPTH_W(8), .UNIT_CYCLES(4), .GAP_UNITS(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_pause(pause),
    .i_mem_data(mem_data), .i_mem_ready(mem_ready), .i_mem_duration(mem_duration),
    .o_mem_read_en(mem_read_en), .o_mem_read_rst(mem_read_rst), .o_note_out(note_out),
    .o_note_valid(note_valid), .o_position(position), .o_busy(busy), .o_finished(finished)
  );

  // Memory responder: data and ready appear the cycle after a read request.
  always @(posedge clk) begin
    if (rst || mem_read_rst) begin
      mem_ptr   <= 8'd0;
      mem_ready <= 1'b0;
      mem_data  <= 12'd0;
    end else if (mem_read_en) begin
      mem_data  <= mem_arr[mem_ptr[2:0]];
      mem_ptr   <= mem_ptr + 8'd1;
      mem_ready <= !mem_hold;
    end else begin
      mem_ready <= 1'b0;
    end
  end

  task automatic go_idle();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if ({note_out, note_valid, position, busy, finished, mem_read_en, mem_read_rst} !== 21'd0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", {note_out, note_valid, position, busy, finished, mem_read_en, mem_read_rst});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %0d expected 0", busy); end
  endtask

  task automatic test_normal_song();
    int cnt40 = 0, cnt45 = 0, valid_cnt = 0, rest_valid = 0, rd_cnt = 0, dbl_rd = 0;
    int fin_cnt = 0, fin_at = -1, first40 = -1, first45 = -1;
    logic prev_rd = 1'b0;
    go_idle();
    mem_arr[0] = 12'h402; mem_arr[1] = 12'h001; mem_arr[2] = 12'h453;
    mem_duration = 8'd3;
    start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (note_out == 8'h40) begin cnt40++; if (first40 < 0) first40 = i; end
      if (note_out == 8'h45) begin cnt45++; if (first45 < 0) first45 = i; end
      if (note_valid) valid_cnt++;
      if (note_valid && i >= 18 && i <= 21) rest_valid++;
      if (mem_read_en) begin rd_cnt++; if (prev_rd) dbl_rd++; end
      prev_rd = mem_read_en;
      if (finished) begin fin_cnt++; fin_at = i; end
    end
    tests++; if (first40 !== 4) begin fails++; $display("FAIL song_first_note_latency: got %0d expected 4", first40); end
    tests++; if (cnt40 !== 8) begin fails++; $display("FAIL song_note40_len: got %0d expected 8", cnt40); end
    tests++; if (first45 !== 28) begin fails++; $display("FAIL song_note45_start: got %0d expected 28", first45); end
    tests++; if (cnt45 !== 12) begin fails++; $display("FAIL song_note45_len: got %0d expected 12", cnt45); end
    tests++; if (valid_cnt !== 20) begin fails++; $display("FAIL song_valid_cycles: got %0d expected 20", valid_cnt); end
    tests++; if (rest_valid !== 0) begin fails++; $display("FAIL song_rest_valid: got %0d expected 0", rest_valid); end
    tests++; if (rd_cnt !== 3) begin fails++; $display("FAIL song_read_count: got %0d expected 3", rd_cnt); end
    tests++; if (dbl_rd !== 0) begin fails++; $display("FAIL song_read_back_to_back: got %0d expected 0", dbl_rd); end
    tests++; if (fin_cnt !== 1) begin fails++; $display("FAIL song_finished_count: got %0d expected 1", fin_cnt); end
    tests++; if (fin_at !== 45) begin fails++; $display("FAIL song_finished_cycle: got %0d expected 45", fin_at); end
    tests++; if (position !== 8'd3) begin fails++; $display("FAIL song_final_position: got %0d expected 3", position); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL song_final_busy: got %0d expected 0", busy); end
  endtask

  task automatic test_empty_song();
    int rd_cnt = 0, fin_cnt = 0, fin_at = -1, busy_cnt = 0;
    go_idle();
    mem_duration = 8'd0;
    start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_read_en) rd_cnt++;
      if (busy) busy_cnt++;
      if (finished) begin fin_cnt++; fin_at = i; end
    end
    tests++; if (fin_at !== 1) begin fails++; $display("FAIL empty_finished_cycle: got %0d expected 1", fin_at); end
    tests++; if (fin_cnt !== 1) begin fails++; $display("FAIL empty_finished_count: got %0d expected 1", fin_cnt); end
    tests++; if (rd_cnt !== 0) begin fails++; $display("FAIL empty_read_count: got %0d expected 0", rd_cnt); end
    tests++; if (busy_cnt !== 0) begin fails++; $display("FAIL empty_busy_cycles: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_end_marker();
    int rd_cnt = 0, fin_cnt = 0, fin_at = -1, cnt30 = 0;
    go_idle();
    mem_arr[0] = 12'h111; mem_arr[1] = 12'h221; mem_arr[2] = 12'h300;
    mem_arr[3] = 12'h441; mem_arr[4] = 12'h551;
    mem_duration = 8'd5;
    start = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_read_en) rd_cnt++;
      if (note_out == 8'h30) cnt30++;
      if (finished) begin fin_cnt++; fin_at = i; end
    end
    tests++; if (fin_at !== 24) begin fails++; $display("FAIL marker_finished_cycle: got %0d expected 24", fin_at); end
    tests++; if (fin_cnt !== 1) begin fails++; $display("FAIL marker_finished_count: got %0d expected 1", fin_cnt); end
    tests++; if (position !== 8'd2) begin fails++; $display("FAIL marker_position: got %0d expected 2", position); end
    tests++; if (cnt30 !== 0) begin fails++; $display("FAIL marker_note_played: got %0d expected 0", cnt30); end
    tests++; if (rd_cnt !== 3) begin fails++; $display("FAIL marker_read_count: got %0d expected 3", rd_cnt); end
  endtask

  task automatic test_pause();
    int cnt45 = 0, paused_note = 0, paused_busy = 0, last45 = -1, fin_at = -1;
    go_idle();
    mem_arr[0] = 12'h453;
    mem_duration = 8'd1;
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (note_out == 8'h45) begin cnt45++; last45 = i; end
      if (i >= 9 && i <= 18 && (note_out != 8'h00 || note_valid)) paused_note++;
      if (i >= 9 && i <= 18 && busy) paused_busy++;
      if (finished) fin_at = i;
      pause = (i >= 8 && i < 18);
    end
    tests++; if (cnt45 !== 12) begin fails++; $display("FAIL pause_on_time: got %0d expected 12", cnt45); end
    tests++; if (paused_note !== 0) begin fails++; $display("FAIL pause_silent: got %0d expected 0", paused_note); end
    tests++; if (paused_busy !== 10) begin fails++; $display("FAIL pause_busy: got %0d expected 10", paused_busy); end
    tests++; if (last45 !== 25) begin fails++; $display("FAIL pause_resume_end: got %0d expected 25", last45); end
    tests++; if (fin_at !== 31) begin fails++; $display("FAIL pause_finished_cycle: got %0d expected 31", fin_at); end
  endtask

  task automatic test_stop_replay();
    int cnt50 = 0, cnt51 = 0, first50 = -1, rd_cnt = 0, fin_cnt = 0, fin_at = -1;
    go_idle();
    mem_arr[0] = 12'h502; mem_arr[1] = 12'h511;
    mem_duration = 8'd2;
    mem_hold = 1'b1;
    start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 5) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL stop_wait_busy: got %0d expected 1", busy); end
      end
      if (i == 6) begin
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stop_to_idle: got busy %0d expected 0", busy); end
        tests++; if (mem_read_rst !== 1'b1) begin fails++; $display("FAIL stop_read_rst: got %0d expected 1", mem_read_rst); end
        tests++; if (note_out !== 8'h00) begin fails++; $display("FAIL stop_note: got %h expected 00", note_out); end
        mem_hold = 1'b0;
      end
      stop = (i == 5);
    end
    start = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      start = (j == 6);
      if (note_out == 8'h50) begin cnt50++; if (first50 < 0) first50 = j; end
      if (note_out == 8'h51) cnt51++;
      if (mem_read_en) rd_cnt++;
      if (finished) begin fin_cnt++; fin_at = j; end
    end
    tests++; if (first50 !== 4) begin fails++; $display("FAIL replay_first_note: got %0d expected 4", first50); end
    tests++; if (cnt50 !== 8) begin fails++; $display("FAIL replay_note50_len: got %0d expected 8", cnt50); end
    tests++; if (cnt51 !== 4) begin fails++; $display("FAIL replay_note51_len: got %0d expected 4", cnt51); end
    tests++; if (rd_cnt !== 2) begin fails++; $display("FAIL replay_read_count: got %0d expected 2", rd_cnt); end
    tests++; if (fin_cnt !== 1) begin fails++; $display("FAIL replay_finished_count: got %0d expected 1", fin_cnt); end
    tests++; if (fin_at !== 27) begin fails++; $display("FAIL replay_finished_cycle: got %0d expected 27", fin_at); end
  endtask

  task automatic test_reset_and_priority();
    go_idle();
    mem_arr[0] = 12'h601; mem_arr[1] = 12'h613;
    mem_duration = 8'd2;
    start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    tests++; if (position !== 8'd1) begin fails++; $display("FAIL rst_pre_position: got %0d expected 1", position); end
    tests++; if (note_out !== 8'h61) begin fails++; $display("FAIL rst_pre_note: got %h expected 61", note_out); end
    rst = 1'b1;
    @(negedge clk);
    tests++; if ({note_out, note_valid, position, busy, finished, mem_read_en, mem_read_rst} !== 21'd0) begin
      fails++; $display("FAIL rst_in_play: got %h expected 0", {note_out, note_valid, position, busy, finished, mem_read_en, mem_read_rst});
    end
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    tests++; if (note_out !== 8'h60) begin fails++; $display("FAIL prio_pre_note: got %h expected 60", note_out); end
    stop = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL prio_stop_busy: got %0d expected 0", busy); end
    tests++; if ({note_out, note_valid} !== 9'd0) begin fails++; $display("FAIL prio_stop_note: got %h expected 0", {note_out, note_valid}); end
    tests++; if (mem_read_rst !== 1'b1) begin fails++; $display("FAIL prio_stop_read_rst: got %0d expected 1", mem_read_rst); end
    repeat (2) @(negedge clk);
    pause = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL prio_stays_idle: got %0d expected 0", busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    mem_hold = 1'b0; mem_duration = 8'd0;
    for (int k = 0; k < 8; k++) mem_arr[k] = 12'h000;
    test_reset();
    test_normal_song();
    test_empty_song();
    test_end_marker();
    test_pause();
    test_stop_replay();
    test_reset_and_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/playback_sequencer.md
# playback_sequencer

Controller that drives the read side of a music memory unit during the AUTOPLAY, LEARNING and GAME states. On `start` it rewinds the memory, fetches one note word at a time with a single-cycle `read_en`, holds each note for its encoded length in time units, and inserts a fixed silent gap between notes. It ends on the stored `duration` count or on an end marker. It sits between the top-level mode FSM and the memory unit, and feeds the buzzer/tone generator and the LED/score logic.

## Interface
- `NOTE_W`, 8: note code field width; code 0 means rest.
- `LEN_W`, 4: length field width, in time units.
- `DATA_W`, 12: memory word width, `NOTE_W + LEN_W`. The word is {note[DATA_W-1:LEN_W], len[LEN_W-1:0]}.
- `DEPTH_W`, 8: width of the `duration` and `position` counts.
- `UNIT_CYCLES`, 6_250_000: clock cycles per time unit (62.5 ms at 100 MHz).
- `GAP_UNITS`, 1: silent units inserted after every note.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins playback from entry 0.
- `stop` in 1: one-cycle pulse that aborts playback.
- `pause` in 1: level input; playback is frozen while it is high.
- `mem_data` in DATA_W: word from the memory unit.
- `mem_ready` in 1: memory output-ready flag.
- `mem_duration` in DEPTH_W: number of stored entries.
- `mem_read_en` out 1: one-cycle read request.
- `mem_read_rst` out 1: rewinds the memory read pointer.
- `note_out` out NOTE_W: current note code; 0 when silent.
- `note_valid` out 1: high while a non-rest note is sounding.
- `position` out DEPTH_W: index of the entry currently playing.
- `busy` out 1: high in any state other than IDLE and DONE.
- `finished` out 1: one-cycle pulse when the song ends normally.

## Operation
States: IDLE, REWIND, FETCH, WAIT, PLAY, GAP, PAUSED, DONE.
- **IDLE**
  - `start` with `mem_duration == 0` → DONE.
  - `start` otherwise → REWIND.
  - All other inputs are ignored.
- **REWIND**: `mem_read_rst` = 1 for one cycle; `position` ← 0; → FETCH.
- **FETCH**
  - If `position == mem_duration` → DONE.
  - Otherwise `mem_read_en` = 1 for exactly one cycle; → WAIT.
- **WAIT**: on the first cycle with `mem_ready` = 1, latch `mem_data`.
  - Length field 0 is the end marker → DONE.
  - Otherwise load the unit counter with len → PLAY.
  - No timeout; `stop` is the escape.
- **PLAY**
  - `note_out` = latched note; `note_valid` = (note ≠ 0).
  - The prescaler counts 0..UNIT_CYCLES-1. Each wrap decrements the unit counter.
  - When the counter reaches 0 → GAP, loaded with `GAP_UNITS`. If `GAP_UNITS == 0`, go straight to FETCH.
- **GAP**: `note_out` = 0. On expiry, `position` += 1 → FETCH.
- **PAUSED**
  - Entered from PLAY or GAP while `pause` = 1.
  - Prescaler, unit counter and `position` are frozen; `note_out` = 0 and `note_valid` = 0.
  - When `pause` = 0, return to the saved state with counts intact.
  - `pause` has no effect in IDLE, REWIND, FETCH, WAIT or DONE; it takes effect on entry to PLAY.
- **DONE**
  - `finished` = 1 on the entry cycle only; `note_out` = 0.
  - `start` → REWIND. This is the replay path.
- **`stop`** in any non-IDLE state: → IDLE and `mem_read_rst` = 1 for that cycle.
- **Priority**: `rst` > `stop` > `pause` > timer/`start`.
- **Arithmetic**
  - Unit counter is LEN_W bits.
  - Prescaler is `$clog2(UNIT_CYCLES)` bits and is cleared on every state entry.
  - `position` saturates at `mem_duration`; it never wraps.

## Timing
- All outputs are registered.
- Reset values: `note_out` = 0, `note_valid` = 0, `position` = 0, `busy` = 0, `finished` = 0, `mem_read_en` = 0, `mem_read_rst` = 0; state = IDLE.
- With an immediate `mem_ready`:
  - `start` at cycle 0 → REWIND at 1 → FETCH at 2 (`mem_read_en` high) → WAIT at 3 → first note on `note_out` at cycle 4.
  - A note of len L plays for exactly L·UNIT_CYCLES cycles, then the gap lasts GAP_UNITS·UNIT_CYCLES cycles.
  - Between consecutive notes there are 2 further cycles (FETCH, WAIT) of silence.
- `finished` asserts 1 cycle after the last GAP ends.
- `stop` takes effect on the next edge. `note_out` = 0 one cycle after `stop` is sampled.
- `mem_read_en` is never asserted for two consecutive cycles.

## Structure
- The shared package / `MemoryPara.v` holds:
  - the state encodings;
  - the note/length field split macros;
  - the end-marker constant (len = 0);
  - the rest note code (0).
- One sub-module, `unit_timer`: the prescaler plus down-counter, with load, enable (≠ paused) and expire outputs. It is shared by PLAY and GAP.

## Test plan
Run all scenarios with UNIT_CYCLES = 4 and GAP_UNITS = 1.
1. **Normal song**: duration 3, words {0x40,2}, {0x00,1}, {0x45,3}.
   - `note_out` = 0x40 for 8 cycles, then silence, then 0x45 for 12 cycles.
   - `note_valid` stays low during the rest entry.
   - `finished` pulses once; `position` ends at 3.
2. **Empty song**: duration 0, `start` → DONE on the next cycle and `finished` pulses. `mem_read_en` never asserts.
3. **End marker**: duration 5, word 2 = {0x30,0}. Playback ends after entry 1 with `finished`; `position` = 2.
4. **Pause**: `pause` high for 10 cycles in the middle of a len-3 note. The note resumes with the same remaining cycles, so total on-time is 12 cycles, and `note_out` = 0 while paused.
5. **Stop and replay**: `stop` during WAIT with `mem_ready` held low.
   - → IDLE with `mem_read_rst` pulsed.
   - A new `start` replays from entry 0.
   - `start` asserted during PLAY is ignored.
6. **Reset**: `rst` during PLAY → all outputs return to reset values on the next edge. `stop` and `pause` asserted on the same cycle → `stop` wins.
